// File: rtl/dyn_reconf_bank.sv
// DRP register bank with a configurable address map, reset values, read-only mask and access latency.
// Write strobes let the clocking core react to each committed reconfiguration write.
module dyn_reconf_bank #(
  parameter int                          DATA_W    = 16,
  parameter int                          ADDR_W    = 7,
  parameter int                          NUM_REGS  = 23,
  parameter logic [NUM_REGS*ADDR_W-1:0]  ADDR_MAP  = {7'h4F, 7'h4E, 7'h28, 7'h1A, 7'h19, 7'h18,
                                                      7'h16, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11,
                                                      7'h10, 7'h0F, 7'h0E, 7'h0D, 7'h0C, 7'h0B,
                                                      7'h0A, 7'h09, 7'h08, 7'h07, 7'h06},
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
  parameter int                          LATENCY   = 1
) (
  input  logic                         DCLK,
  input  logic                         RST_N,
  input  logic                         PWRDWN,
  input  logic [ADDR_W-1:0]            DADDR,
  input  logic                         DEN,
  input  logic                         DWE,
  input  logic [DATA_W-1:0]            DI,
  output logic [DATA_W-1:0]            DO,
  output logic                         DRDY,
  output logic                         DERR,
  output logic                         DOVL,
  output logic [NUM_REGS*DATA_W-1:0]   REGS,
  output logic [NUM_REGS-1:0]          REG_WR_STB
);

  // Counter holds LATENCY-1, so 3 bits cover the full 1..8 latency range.
  localparam int CNT_W = 3;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_p0;
  logic                we_p0;
  logic [DATA_W-1:0]   di_p0;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (addr_p0 == ADDR_MAP[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign REGS[g*DATA_W +: DATA_W] = regs_q[g];
  end

  // ---- stage p0: request capture (data path, no reset) ----
  always_ff @(posedge DCLK) begin
    if (state == IDLE && DEN && !PWRDWN) begin
      addr_p0 <= DADDR;
      we_p0   <= DWE;
      di_p0   <= DI;
    end
  end

  // ---- access FSM, commit and response ----
  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      DO         <= '0;
      DRDY       <= 1'b0;
      DERR       <= 1'b0;
      DOVL       <= 1'b0;
      REG_WR_STB <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else if (PWRDWN) begin
      state      <= IDLE;
      cnt        <= '0;
      DO         <= '0;
      DRDY       <= 1'b0;
      DERR       <= 1'b0;
      REG_WR_STB <= '0;
    end else begin
      DRDY       <= 1'b0;
      DERR       <= 1'b0;
      REG_WR_STB <= '0;
      case (state)
        IDLE: begin
          if (DEN) begin
            cnt   <= CNT_W'(LATENCY - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (DEN) begin
            DOVL <= 1'b1;
          end
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
            DRDY  <= 1'b1;
            if (we_p0) begin
              if (hit && !RO_MASK[hit_idx]) begin
                regs_q[hit_idx]     <= di_p0;
                REG_WR_STB[hit_idx] <= 1'b1;
              end else begin
                DERR <= 1'b1;
              end
            end else if (hit) begin
              DO <= regs_q[hit_idx];
            end else begin
              DO   <= '0;
              DERR <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_reconf_bank.sv
// Directed bench: three bank instances (LATENCY 1, 3, 4) share the request bus, each with its own DEN.
module tb_dyn_reconf_bank;

  localparam logic [367:0] RV  = (368'h0F0F << (22*16)) | (368'h5A5A << (4*16)) | 368'hA5A5;
  localparam logic [22:0]  ROM = 23'h400000;

  logic        DCLK;
  logic        RST_N;
  logic        PWRDWN;
  logic [6:0]  DADDR;
  logic        DWE;
  logic [15:0] DI;
  logic        den   [3];
  logic [15:0] dout  [3];
  logic        drdy  [3];
  logic        derr  [3];
  logic        dovl  [3];
  logic [367:0] regs [3];
  logic [22:0] stb   [3];

  int tests  = 0;
  int failed = 0;
  int lat [3] = '{1, 3, 4};

  dyn_reconf_bank #(.RESET_VAL(RV), .RO_MASK(ROM), .LATENCY(1)) u_l1 (
    .DCLK(DCLK), .RST_N(RST_N), .PWRDWN(PWRDWN), .DADDR(DADDR), .DEN(den[0]),
    .DWE(DWE), .DI(DI), .DO(dout[0]), .DRDY(drdy[0]), .DERR(derr[0]), .DOVL(dovl[0]),
    .REGS(regs[0]), .REG_WR_STB(stb[0]));

  dyn_reconf_bank #(.RESET_VAL(RV), .RO_MASK(ROM), .LATENCY(3)) u_l3 (
    .DCLK(DCLK), .RST_N(RST_N), .PWRDWN(PWRDWN), .DADDR(DADDR), .DEN(den[1]),
    .DWE(DWE), .DI(DI), .DO(dout[1]), .DRDY(drdy[1]), .DERR(derr[1]), .DOVL(dovl[1]),
    .REGS(regs[1]), .REG_WR_STB(stb[1]));

  dyn_reconf_bank #(.RESET_VAL(RV), .RO_MASK(ROM), .LATENCY(4)) u_l4 (
    .DCLK(DCLK), .RST_N(RST_N), .PWRDWN(PWRDWN), .DADDR(DADDR), .DEN(den[2]),
    .DWE(DWE), .DI(DI), .DO(dout[2]), .DRDY(drdy[2]), .DERR(derr[2]), .DOVL(dovl[2]),
    .REGS(regs[2]), .REG_WR_STB(stb[2]));

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  function automatic logic [15:0] rg(input int u, input int i);
    logic [367:0] v;
    v = regs[u];
    return v[i*16 +: 16];
  endfunction

  task automatic start(input int u, input logic we, input logic [6:0] a, input logic [15:0] d);
    DADDR = a;
    DWE   = we;
    DI    = d;
    den[u] = 1'b1;
    tick();
    den[u] = 1'b0;
  endtask

  // Bounded wait: returns the number of edges until DRDY, or 16 on timeout.
  task automatic wait_drdy(input int u, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!drdy[u] && n < 16);
  endtask

  task automatic watch_none(input int u, input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (drdy[u]) seen++;
    end
  endtask

  initial begin
    int n;
    int seen;
    int seen0;
    RST_N  = 1'b0;
    PWRDWN = 1'b0;
    DADDR  = '0;
    DWE    = 1'b0;
    DI     = '0;
    for (int u = 0; u < 3; u++) den[u] = 1'b0;

    // 1: reset values
    tick();
    tick();
    chk("rst_reg0", 32'(rg(0, 0)), 32'hA5A5);
    chk("rst_reg4", 32'(rg(2, 4)), 32'h5A5A);
    chk("rst_do",   32'(dout[0]), 32'h0);
    chk("rst_drdy", 32'(drdy[0]), 32'h0);
    chk("rst_dovl", 32'(dovl[0]), 32'h0);
    RST_N = 1'b1;
    tick();
    start(0, 1'b0, 7'h06, 16'h0);
    wait_drdy(0, n);
    chk("rd06_lat",  32'(n), 32'(lat[0]));
    chk("rd06_do",   32'(dout[0]), 32'hA5A5);
    chk("rd06_derr", 32'(derr[0]), 32'h0);

    // 2: LATENCY=3 write and readback
    start(1, 1'b1, 7'h08, 16'h1234);
    wait_drdy(1, n);
    chk("wr08_lat",  32'(n), 32'(lat[1]));
    chk("wr08_stb",  32'(stb[1]), 32'h4);
    chk("wr08_reg",  32'(rg(1, 2)), 32'h1234);
    chk("wr08_derr", 32'(derr[1]), 32'h0);
    chk("wr08_do",   32'(dout[1]), 32'h0);
    tick();
    chk("wr08_drdy_off", 32'(drdy[1]), 32'h0);
    chk("wr08_stb_off",  32'(stb[1]), 32'h0);
    start(1, 1'b0, 7'h08, 16'h0);
    wait_drdy(1, n);
    chk("rd08_lat", 32'(n), 32'(lat[1]));
    chk("rd08_do",  32'(dout[1]), 32'h1234);

    // 3: unmapped read, read-only write
    start(1, 1'b0, 7'h7F, 16'h0);
    wait_drdy(1, n);
    chk("rd7f_lat",  32'(n), 32'(lat[1]));
    chk("rd7f_do",   32'(dout[1]), 32'h0);
    chk("rd7f_derr", 32'(derr[1]), 32'h1);
    start(1, 1'b1, 7'h4F, 16'hFFFF);
    wait_drdy(1, n);
    chk("wr4f_lat",  32'(n), 32'(lat[1]));
    chk("wr4f_derr", 32'(derr[1]), 32'h1);
    chk("wr4f_stb",  32'(stb[1]), 32'h0);
    chk("wr4f_reg",  32'(rg(1, 22)), 32'h0F0F);
    tick();
    chk("derr_idle", 32'(derr[1]), 32'h0);

    // 4: overlap at LATENCY=4; second request would read 0 from 0x08
    DADDR = 7'h06;
    DWE   = 1'b0;
    den[2] = 1'b1;
    tick();
    DADDR = 7'h08;
    tick();
    den[2] = 1'b0;
    chk("ovl_set", 32'(dovl[2]), 32'h1);
    wait_drdy(2, n);
    chk("ovl_lat", 32'(n), 32'(lat[2] - 1));
    chk("ovl_do",  32'(dout[2]), 32'hA5A5);
    watch_none(2, 8, seen);
    chk("ovl_one_drdy", 32'(seen), 32'h0);
    chk("ovl_sticky",   32'(dovl[2]), 32'h1);
    chk("ovl_other",    32'(dovl[0]), 32'h0);

    // 5a: power-down abort; DEN to the idle LATENCY=1 bank is ignored
    start(2, 1'b1, 7'h0A, 16'hBEEF);
    tick();
    PWRDWN = 1'b1;
    den[0] = 1'b1;
    tick();
    PWRDWN = 1'b0;
    den[0] = 1'b0;
    chk("pd_do", 32'(dout[2]), 32'h0);
    seen0 = 0;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (drdy[2]) seen++;
      if (drdy[0]) seen0++;
    end
    chk("pd_no_drdy",  32'(seen), 32'h0);
    chk("pd_den_ign",  32'(seen0), 32'h0);
    chk("pd_reg4",     32'(rg(2, 4)), 32'h5A5A);
    chk("pd_dovl_l1",  32'(dovl[0]), 32'h0);

    // 5b: reset abort after a committed write
    start(2, 1'b1, 7'h0A, 16'h1111);
    wait_drdy(2, n);
    chk("wr0a_lat", 32'(n), 32'(lat[2]));
    chk("wr0a_reg", 32'(rg(2, 4)), 32'h1111);
    start(2, 1'b1, 7'h0A, 16'hBEEF);
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    watch_none(2, 8, seen);
    chk("rs_no_drdy", 32'(seen), 32'h0);
    chk("rs_reg4",    32'(rg(2, 4)), 32'h5A5A);
    chk("rs_dovl",    32'(dovl[2]), 32'h0);

    // 6: back-to-back at LATENCY=1
    start(0, 1'b1, 7'h4E, 16'h00C3);
    wait_drdy(0, n);
    chk("wr4e_lat", 32'(n), 32'(lat[0]));
    chk("wr4e_stb", 32'(stb[0]), 32'h200000);
    start(0, 1'b0, 7'h4E, 16'h0);
    wait_drdy(0, n);
    chk("b2b_lat",  32'(n), 32'(lat[0]));
    chk("b2b_do",   32'(dout[0]), 32'h00C3);
    chk("b2b_dovl", 32'(dovl[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
